// File: rtl/reflet_spi_pkg.sv
// ============================================================================
//  Module      : reflet_spi_pkg
//  Description : Register map, bit positions and FSM encoding for reflet_spi.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reflet_spi_pkg;

  localparam int c_spi_size = 4;

  localparam logic [1:0] c_reg_ctrl   = 2'd0;
  localparam logic [1:0] c_reg_div    = 2'd1;
  localparam logic [1:0] c_reg_data   = 2'd2;
  localparam logic [1:0] c_reg_status = 2'd3;

  localparam int c_ctrl_en    = 0;
  localparam int c_ctrl_cpol  = 1;
  localparam int c_ctrl_cpha  = 2;
  localparam int c_ctrl_cs    = 3;
  localparam int c_ctrl_ie    = 4;
  localparam int c_ctrl_width = 5;

  localparam int c_stat_busy = 0;
  localparam int c_stat_done = 1;
  localparam int c_stat_ovr  = 2;

  localparam logic [0:0] c_st_idle  = 1'b0;
  localparam logic [0:0] c_st_shift = 1'b1;

endpackage

`default_nettype wire

// File: rtl/reflet_spi_clkgen.sv
// ============================================================================
//  Module      : reflet_spi_clkgen
//  Description : SCLK timebase; half-period and edge counters with strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reflet_spi_clkgen (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       run,
  input  logic [7:0] div,
  output logic       lead,
  output logic       trail,
  output logic       last
);

  logic [7:0] r_half_cnt;
  logic [3:0] r_edge_cnt;
  logic       w_wrap;
  logic       w_tick;

  assign w_wrap = (r_half_cnt == div);
  // Strobes are masked on start/abort so a restarting or dying transfer never sees an edge.
  assign w_tick = run && w_wrap && !start && !abort;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_half_cnt <= 8'd0;
      r_edge_cnt <= 4'd0;
    end else if (start || abort) begin
      r_half_cnt <= 8'd0;
      r_edge_cnt <= 4'd0;
    end else if (run) begin
      if (w_wrap) begin
        r_half_cnt <= 8'd0;
        r_edge_cnt <= r_edge_cnt + 4'd1;
      end else begin
        r_half_cnt <= r_half_cnt + 8'd1;
      end
    end
  end

  assign lead  = w_tick && !r_edge_cnt[0];
  assign trail = w_tick &&  r_edge_cnt[0];
  assign last  = w_tick && (r_edge_cnt == 4'd15);

endmodule

`default_nettype wire

// File: rtl/reflet_spi.sv
// ============================================================================
//  Module      : reflet_spi
//  Description : Byte-wide SPI master with a four-register peripheral-bus map.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reflet_spi
  import reflet_spi_pkg::*;
#(
  parameter int          base_addr_size = 16,
  parameter int unsigned base_addr      = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [base_addr_size-1:0] addr,
  input  logic [7:0]                data_in,
  output logic [7:0]                data_out,
  input  logic                      write_en,
  output logic                      interrupt,
  output logic                      sclk,
  output logic                      mosi,
  input  logic                      miso,
  output logic                      cs_n
);

  localparam logic [base_addr_size:0] c_base_lo = (base_addr_size+1)'(base_addr);
  localparam logic [base_addr_size:0] c_base_hi = (base_addr_size+1)'(base_addr + c_spi_size);

  logic [c_ctrl_width-1:0] r_ctrl;
  logic [7:0]              r_div;
  logic [7:0]              r_rx_data;
  logic                    r_done;
  logic                    r_ovr;
  logic [0:0]              r_state;
  logic [0:0]              w_state_next;
  logic [7:0]              r_tx;
  logic [7:0]              r_rx;
  logic                    r_sclk;
  logic                    r_mosi;

  logic       w_sel;
  logic [1:0] w_off;
  logic       w_we;
  logic       w_ctrl_we;
  logic       w_div_we;
  logic       w_data_we;
  logic       w_status_we;
  logic       w_busy;
  logic       w_idle;
  logic       w_start;
  logic       w_abort;
  logic       w_lead;
  logic       w_trail;
  logic       w_last;
  logic       w_cpha;
  logic       w_sample;
  logic       w_shift_out;
  logic [7:0] w_rx_next;
  logic [7:0] w_rdata;

  assign w_sel       = enable && ({1'b0, addr} >= c_base_lo) && ({1'b0, addr} < c_base_hi);
  assign w_off       = addr[1:0] - c_base_lo[1:0];
  assign w_we        = w_sel && write_en;
  assign w_ctrl_we   = w_we && (w_off == c_reg_ctrl);
  assign w_div_we    = w_we && (w_off == c_reg_div);
  assign w_data_we   = w_we && (w_off == c_reg_data);
  assign w_status_we = w_we && (w_off == c_reg_status);

  assign w_start = w_data_we && r_ctrl[c_ctrl_en] && w_idle;
  // Clearing EN kills the transfer on the very edge that writes it.
  assign w_abort = w_busy && w_ctrl_we && !data_in[c_ctrl_en];

  reflet_spi_clkgen u_clkgen (
    .clk   (clk),
    .reset (reset),
    .start (w_start),
    .abort (w_abort),
    .run   (w_busy),
    .div   (r_div),
    .lead  (w_lead),
    .trail (w_trail),
    .last  (w_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle:  if (w_start) w_state_next = c_st_shift;
      c_st_shift: if (w_abort || w_last) w_state_next = c_st_idle;
      default:    w_state_next = c_st_idle;
    endcase
  end

  always_comb begin
    w_busy = (r_state == c_st_shift);
    w_idle = (r_state == c_st_idle);
  end

  // With CPHA=0 bit7 goes out at start, so the remaining bits queue up pre-shifted.
  assign w_cpha      = r_ctrl[c_ctrl_cpha];
  assign w_sample    = w_cpha ? w_trail : w_lead;
  assign w_shift_out = w_cpha ? w_lead  : (w_trail && !w_last);
  assign w_rx_next   = w_sample ? {r_rx[6:0], miso} : r_rx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx   <= 8'd0;
      r_rx   <= 8'd0;
      r_sclk <= 1'b0;
      r_mosi <= 1'b0;
    end else if (w_start) begin
      r_tx   <= w_cpha ? data_in : {data_in[6:0], 1'b0};
      r_rx   <= 8'd0;
      r_sclk <= r_ctrl[c_ctrl_cpol];
      if (!w_cpha) r_mosi <= data_in[7];
    end else if (w_busy && !w_abort) begin
      r_rx <= w_rx_next;
      if (w_lead || w_trail) r_sclk <= ~r_sclk;
      if (w_shift_out) begin
        r_mosi <= r_tx[7];
        r_tx   <= {r_tx[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl    <= '0;
      r_div     <= 8'd0;
      r_rx_data <= 8'd0;
      r_done    <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      if (w_ctrl_we) r_ctrl <= data_in[c_ctrl_width-1:0];
      if (w_div_we)  r_div  <= data_in;
      if (w_last)    r_rx_data <= w_rx_next;
      // Flag sets take priority over a same-edge write-1-to-clear.
      if (w_last)                                r_done <= 1'b1;
      else if (w_status_we && data_in[c_stat_done]) r_done <= 1'b0;
      if (w_data_we && w_busy)                   r_ovr <= 1'b1;
      else if (w_status_we && data_in[c_stat_ovr])  r_ovr <= 1'b0;
    end
  end

  always_comb begin
    w_rdata = 8'd0;
    case (w_off)
      c_reg_ctrl:   w_rdata = {3'd0, r_ctrl};
      c_reg_div:    w_rdata = r_div;
      c_reg_data:   w_rdata = r_rx_data;
      c_reg_status: w_rdata = {5'd0, r_ovr, r_done, w_busy};
      default:      w_rdata = 8'd0;
    endcase
  end

  assign data_out  = w_sel ? w_rdata : 8'd0;
  assign sclk      = w_busy ? r_sclk : r_ctrl[c_ctrl_cpol];
  assign mosi      = r_mosi;
  assign cs_n      = ~r_ctrl[c_ctrl_cs];
  assign interrupt = r_done & r_ctrl[c_ctrl_ie];

endmodule

`default_nettype wire

// File: tb/tb_reflet_spi.sv
// ============================================================================
//  Module      : tb_reflet_spi
//  Description : Scoreboard bench for reflet_spi; directed bus and SPI vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reflet_spi;

  localparam logic [15:0] c_a_ctrl = 16'd0;
  localparam logic [15:0] c_a_div  = 16'd1;
  localparam logic [15:0] c_a_data = 16'd2;
  localparam logic [15:0] c_a_stat = 16'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        write_en = 1'b0;
  logic [15:0] addr = 16'd0;
  logic [7:0]  data_in = 8'd0;
  logic [7:0]  data_out;
  logic        interrupt;
  logic        sclk;
  logic        mosi;
  logic        miso;
  logic        cs_n;
  logic        miso_tie = 1'b0;
  logic        loopback = 1'b0;

  int checks = 0;
  int failures = 0;

  logic       obs_pending = 1'b0;
  logic       mosi_mon_en = 1'b0;
  logic       obs_kind_q[$];
  logic [7:0] obs_exp_q[$];
  string      obs_name_q[$];
  logic       mosi_q[$];

  assign miso = loopback ? mosi : miso_tie;

  reflet_spi #(.base_addr_size(16), .base_addr(0)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .addr      (addr),
    .data_in   (data_in),
    .data_out  (data_out),
    .write_en  (write_en),
    .interrupt (interrupt),
    .sclk      (sclk),
    .mosi      (mosi),
    .miso      (miso),
    .cs_n      (cs_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic en, input logic [15:0] a, input logic [7:0] d);
    enable = en; addr = a; data_in = d; write_en = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0; write_en = 1'b0;
  endtask

  task automatic bus_read(input logic en, input logic [15:0] a, input logic [7:0] exp,
                          input string name);
    enable = en; addr = a; write_en = 1'b0;
    obs_kind_q.push_back(1'b0); obs_exp_q.push_back(exp); obs_name_q.push_back(name);
    obs_pending = 1'b1;
    @(posedge clk); #1;
    obs_pending = 1'b0; enable = 1'b0;
  endtask

  // Pin snapshot layout: {mosi, sclk, cs_n, interrupt}
  task automatic expect_pins(input logic [7:0] exp, input string name);
    obs_kind_q.push_back(1'b1); obs_exp_q.push_back(exp); obs_name_q.push_back(name);
    obs_pending = 1'b1;
    @(posedge clk); #1;
    obs_pending = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) mosi_q.push_back(b[i]);
  endtask

  logic       mon_kind;
  logic [7:0] mon_exp;
  logic [7:0] mon_act;
  string      mon_name;

  always @(negedge clk) begin
    if (obs_pending) begin
      if (obs_kind_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL scoreboard_empty: got no expectation, required one");
      end else begin
        mon_kind = obs_kind_q.pop_front();
        mon_exp  = obs_exp_q.pop_front();
        mon_name = obs_name_q.pop_front();
        mon_act  = mon_kind ? {4'd0, mosi, sclk, cs_n, interrupt} : data_out;
        check(mon_name, mon_act, mon_exp);
      end
    end
  end

  // Modes 0 and 3 both present valid MOSI at the rising SCLK edge.
  always @(posedge sclk) begin
    if (mosi_mon_en) begin
      #1;
      if (mosi_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL mosi_extra_edge: got an extra rising sclk, required none");
      end else begin
        check("mosi_bit", {7'd0, mosi}, {7'd0, mosi_q.pop_front()});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    bus_read(1, c_a_ctrl, 8'h00, "rst_ctrl");
    bus_read(1, c_a_div,  8'h00, "rst_div");
    bus_read(1, c_a_data, 8'h00, "rst_data");
    bus_read(1, c_a_stat, 8'h00, "rst_status");
    expect_pins(8'h02, "rst_pins");

    // Mode 0, DIV=0, loopback
    loopback = 1'b1;
    bus_write(1, c_a_div, 8'h00);
    bus_write(1, c_a_ctrl, 8'h09);
    push_bits(8'hA5);
    mosi_mon_en = 1'b1;
    bus_write(1, c_a_data, 8'hA5);
    bus_read(1, c_a_stat, 8'h01, "m0_busy_first");
    tick(14);
    bus_read(1, c_a_stat, 8'h01, "m0_busy_last");
    bus_read(1, c_a_stat, 8'h02, "m0_done");
    bus_read(1, c_a_data, 8'hA5, "m0_data");
    mosi_mon_en = 1'b0;
    check("m0_mosi_count", 8'(mosi_q.size()), 8'd0);
    bus_write(1, c_a_stat, 8'h02);

    // Mode 3, DIV=3, miso tied high
    loopback = 1'b0; miso_tie = 1'b1;
    bus_write(1, c_a_div, 8'h03);
    bus_write(1, c_a_ctrl, 8'h0F);
    push_bits(8'h3C);
    mosi_mon_en = 1'b1;
    bus_write(1, c_a_data, 8'h3C);
    bus_read(1, c_a_stat, 8'h01, "m3_busy_first");
    expect_pins(8'h0C, "m3_pins_idle_high");
    tick(2);
    expect_pins(8'h00, "m3_pins_first_edge");
    tick(58);
    bus_read(1, c_a_stat, 8'h01, "m3_busy_last");
    bus_read(1, c_a_stat, 8'h02, "m3_status");
    bus_read(1, c_a_data, 8'hFF, "m3_data");
    expect_pins(8'h04, "m3_pins_end");
    mosi_mon_en = 1'b0;
    check("m3_mosi_count", 8'(mosi_q.size()), 8'd0);
    bus_write(1, c_a_stat, 8'h02);

    // Interrupt and write-1-to-clear
    miso_tie = 1'b0;
    bus_write(1, c_a_div, 8'h00);
    bus_write(1, c_a_ctrl, 8'h11);
    bus_write(1, c_a_data, 8'h5A);
    tick(16);
    expect_pins(8'h03, "irq_raised");
    bus_read(1, c_a_stat, 8'h02, "irq_status");
    bus_write(1, c_a_stat, 8'h02);
    expect_pins(8'h02, "irq_cleared");
    bus_read(1, c_a_stat, 8'h00, "irq_status_clr");
    bus_read(1, c_a_data, 8'h00, "irq_data");
    bus_write(1, c_a_data, 8'h5A);
    tick(15);
    bus_write(1, c_a_stat, 8'h02);
    bus_read(1, c_a_stat, 8'h02, "w1c_set_wins");
    expect_pins(8'h03, "w1c_irq_held");
    bus_write(1, c_a_stat, 8'h02);

    // Overrun
    loopback = 1'b1;
    bus_write(1, c_a_ctrl, 8'h01);
    push_bits(8'h11);
    mosi_mon_en = 1'b1;
    bus_write(1, c_a_data, 8'h11);
    bus_write(1, c_a_data, 8'h22);
    tick(16);
    bus_read(1, c_a_stat, 8'h06, "ovr_status");
    bus_read(1, c_a_data, 8'h11, "ovr_data");
    mosi_mon_en = 1'b0;
    check("ovr_mosi_count", 8'(mosi_q.size()), 8'd0);
    bus_write(1, c_a_stat, 8'h06);
    bus_read(1, c_a_stat, 8'h00, "ovr_cleared");

    // Abort mid-transfer, CPOL=1, DIV=1
    loopback = 1'b0; miso_tie = 1'b1;
    bus_write(1, c_a_div, 8'h01);
    bus_write(1, c_a_ctrl, 8'h03);
    bus_write(1, c_a_data, 8'hF0);
    tick(14);
    expect_pins(8'h0A, "abort_pins_before");
    bus_write(1, c_a_ctrl, 8'h02);
    expect_pins(8'h0E, "abort_pins_after");
    bus_read(1, c_a_stat, 8'h00, "abort_status");
    bus_read(1, c_a_data, 8'h11, "abort_data");

    // Bus select
    bus_write(0, c_a_ctrl, 8'h1F);
    bus_write(1, 16'd4, 8'hFF);
    bus_read(1, c_a_ctrl, 8'h02, "sel_ctrl");
    bus_read(1, c_a_div,  8'h01, "sel_div");
    bus_read(1, 16'd4,    8'h00, "sel_out_of_range");
    bus_read(0, c_a_div,  8'h00, "sel_disabled");

    // Asynchronous reset during a transfer
    bus_write(1, c_a_div, 8'h00);
    bus_write(1, c_a_ctrl, 8'h09);
    bus_write(1, c_a_data, 8'hFF);
    tick(3);
    reset = 1'b1;
    expect_pins(8'h02, "areset_pins");
    bus_read(1, c_a_ctrl, 8'h00, "areset_ctrl");
    bus_read(1, c_a_stat, 8'h00, "areset_status");
    bus_read(1, c_a_data, 8'h00, "areset_data");
    reset = 1'b0;
    expect_pins(8'h02, "post_reset_pins");

    tick(2);
    check("scoreboard_drained", 8'(obs_exp_q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
